// File: rtl/noc_pkg.sv
// Shared types and helpers for the node-side network interface.
package noc_pkg;

  localparam int FLIT_WIDTH_DEF = 64;
  localparam int NODES_DEF      = 6;

  // Width of a destination id; never narrower than one bit.
  function automatic int dest_w(input int nodes);
    return (nodes > 1) ? $clog2(nodes) : 1;
  endfunction

  localparam int DEST_W_DEF = dest_w(NODES_DEF);

  typedef struct packed {
    logic [FLIT_WIDTH_DEF-1:0] data;
    logic                      valid;
    logic                      last;
    logic [DEST_W_DEF-1:0]     dest;
  } flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for one router input buffer. A consume is only honoured
// when credits are available; a return at full count saturates and flags.
module noc_credit_counter #(
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          consume,
  input  logic          credit_in,
  output logic [CW-1:0] cnt,
  output logic          avail,
  output logic          overflow_err
);

  logic take;

  assign avail = (cnt != '0);
  assign take  = consume && avail;

  // Count update: simultaneous take and return cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= CW'(CREDITS);
      overflow_err <= 1'b0;
    end else begin
      overflow_err <= 1'b0;
      if (take && !credit_in) begin
        cnt <= cnt - CW'(1);
      end else if (!take && credit_in) begin
        if (cnt == CW'(CREDITS)) begin
          overflow_err <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/noc_packetizer.sv
// Message-to-flit transmitter feeding one router input port under
// credit-based flow control.
//
//   state | meaning
//   IDLE  | ready for a message; illegal requests are dropped here
//   SEND  | emitting latched message, one flit per edge with a credit
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int NODES      = 6,
  parameter int FLIT_WIDTH = 64,
  parameter int MAX_FLITS  = 8,
  parameter int CREDITS    = 4,
  parameter int DW         = dest_w(NODES),
  parameter int LW         = $clog2(MAX_FLITS + 1),
  parameter int CW         = $clog2(CREDITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [DW-1:0]                 req_dest,
  input  logic [LW-1:0]                 req_len,
  input  logic [MAX_FLITS*FLIT_WIDTH-1:0] req_data,
  output logic                          flit_valid,
  output logic [FLIT_WIDTH-1:0]         flit_data,
  output logic                          flit_last,
  output logic [DW-1:0]                 flit_dest,
  input  logic                          credit_in,
  output logic [CW-1:0]                 credit_cnt,
  output logic                          busy,
  output logic                          err_req,
  output logic                          err_credit
);

  pkt_state_e state, next_state;

  logic [MAX_FLITS*FLIT_WIDTH-1:0] msg_data;
  logic [DW-1:0]                   msg_dest;
  logic [LW-1:0]                   msg_len;
  logic [LW-1:0]                   idx;

  logic req_fire, req_legal, credit_avail, send, is_last;

  assign req_ready = (state == IDLE);
  assign busy      = (state == SEND);
  assign req_fire  = req_valid && req_ready;
  assign req_legal = (req_len != '0) &&
                     (req_len <= LW'(MAX_FLITS)) &&
                     ({1'b0, req_dest} < (DW+1)'(NODES));
  assign send      = (state == SEND) && credit_avail;
  assign is_last   = (idx == msg_len - LW'(1));

  noc_credit_counter #(
    .CREDITS (CREDITS),
    .CW      (CW)
  ) u_credit (
    .clk          (clk),
    .rst_n        (rst_n),
    .consume      (send),
    .credit_in    (credit_in),
    .cnt          (credit_cnt),
    .avail        (credit_avail),
    .overflow_err (err_credit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: accept legal messages, return to IDLE on the last flit.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_fire && req_legal) next_state = SEND;
      SEND:    if (send && is_last)       next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Message latch, beat index and registered flit outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_data   <= '0;
      msg_dest   <= '0;
      msg_len    <= '0;
      idx        <= '0;
      flit_valid <= 1'b0;
      flit_data  <= '0;
      flit_last  <= 1'b0;
      flit_dest  <= '0;
      err_req    <= 1'b0;
    end else begin
      flit_valid <= send;
      flit_last  <= send && is_last;
      err_req    <= req_fire && !req_legal;
      if (req_fire && req_legal) begin
        msg_data <= req_data;
        msg_dest <= req_dest;
        msg_len  <= req_len;
        idx      <= '0;
      end
      if (send) begin
        flit_data <= msg_data[int'(idx)*FLIT_WIDTH +: FLIT_WIDTH];
        flit_dest <= msg_dest;
        idx       <= idx + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer with default parameters.
module tb_noc_packetizer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_dest;
  logic [3:0]   req_len;
  logic [511:0] req_data;
  logic         flit_valid;
  logic [63:0]  flit_data;
  logic         flit_last;
  logic [2:0]   flit_dest;
  logic         credit_in;
  logic [2:0]   credit_cnt;
  logic         busy;
  logic         err_req;
  logic         err_credit;

  int checks = 0;
  int errors = 0;

  noc_packetizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest   (req_dest),
    .req_len    (req_len),
    .req_data   (req_data),
    .flit_valid (flit_valid),
    .flit_data  (flit_data),
    .flit_last  (flit_last),
    .flit_dest  (flit_dest),
    .credit_in  (credit_in),
    .credit_cnt (credit_cnt),
    .busy       (busy),
    .err_req    (err_req),
    .err_credit (err_credit)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] d, input logic [3:0] l, input logic [63:0] base);
    req_valid = 1'b1;
    req_dest  = d;
    req_len   = l;
    req_data  = '0;
    for (int i = 0; i < 8; i++) req_data[i*64 +: 64] = base + 64'(i);
  endtask

  task automatic exp_flit(input string tag, input logic [63:0] d, input logic l,
                          input logic [2:0] dst, input logic [2:0] cnt);
    chk({tag, ".valid"}, 64'(flit_valid), 64'd1);
    chk({tag, ".data"},  flit_data, d);
    chk({tag, ".last"},  64'(flit_last), 64'(l));
    chk({tag, ".dest"},  64'(flit_dest), 64'(dst));
    chk({tag, ".cnt"},   64'(credit_cnt), 64'(cnt));
  endtask

  task automatic pulse_credit();
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_dest = '0; req_len = '0;
    req_data = '0; credit_in = 1'b0;
    repeat (3) tick();
    chk("rst.valid", 64'(flit_valid), 64'd0);
    chk("rst.data",  flit_data, 64'd0);
    chk("rst.cnt",   64'(credit_cnt), 64'd4);
    chk("rst.ready", 64'(req_ready), 64'd1);
    chk("rst.busy",  64'(busy), 64'd0);
    chk("rst.errs",  64'({err_req, err_credit}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic 4-flit packet, no credit returns.
    set_req(3'd3, 4'd4, 64'hA0);
    tick();
    req_valid = 1'b0;
    chk("p1.acc.busy",  64'(busy), 64'd1);
    chk("p1.acc.ready", 64'(req_ready), 64'd0);
    chk("p1.acc.valid", 64'(flit_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_flit($sformatf("p1.f%0d", k), 64'hA0 + 64'(k), (k == 3), 3'd3, 3'(3 - k));
    end
    chk("p1.ready", 64'(req_ready), 64'd1);
    tick();
    chk("p1.after.valid", 64'(flit_valid), 64'd0);

    // Refill credits, then a 6-flit packet that stalls.
    for (int i = 0; i < 4; i++) pulse_credit();
    chk("refill.cnt", 64'(credit_cnt), 64'd4);
    set_req(3'd2, 4'd6, 64'hB0);
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_flit($sformatf("p2.f%0d", k), 64'hB0 + 64'(k), 1'b0, 3'd2, 3'(3 - k));
    end
    tick();
    chk("p2.stall1.valid", 64'(flit_valid), 64'd0);
    chk("p2.stall1.busy",  64'(busy), 64'd1);
    tick();
    chk("p2.stall2.valid", 64'(flit_valid), 64'd0);
    pulse_credit();
    chk("p2.cr1.valid", 64'(flit_valid), 64'd0);
    chk("p2.cr1.cnt",   64'(credit_cnt), 64'd1);
    tick();
    exp_flit("p2.f4", 64'hB4, 1'b0, 3'd2, 3'd0);
    tick();
    chk("p2.stall3.valid", 64'(flit_valid), 64'd0);
    pulse_credit();
    chk("p2.cr2.valid", 64'(flit_valid), 64'd0);
    tick();
    exp_flit("p2.f5", 64'hB5, 1'b1, 3'd2, 3'd0);
    chk("p2.ready", 64'(req_ready), 64'd1);

    // Simultaneous send and credit return at count 2; overflow at full.
    pulse_credit();
    pulse_credit();
    chk("p3.pre.cnt", 64'(credit_cnt), 64'd2);
    set_req(3'd1, 4'd2, 64'hC0);
    tick();
    req_valid = 1'b0;
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    exp_flit("p3.f0", 64'hC0, 1'b0, 3'd1, 3'd2);
    tick();
    exp_flit("p3.f1", 64'hC1, 1'b1, 3'd1, 3'd1);
    for (int i = 0; i < 3; i++) pulse_credit();
    chk("p3.full.cnt", 64'(credit_cnt), 64'd4);
    chk("p3.full.noerr", 64'(err_credit), 64'd0);
    pulse_credit();
    chk("ovf.cnt", 64'(credit_cnt), 64'd4);
    chk("ovf.err", 64'(err_credit), 64'd1);
    tick();
    chk("ovf.err.clear", 64'(err_credit), 64'd0);
    chk("ovf.cnt2", 64'(credit_cnt), 64'd4);

    // Illegal requests back to back.
    set_req(3'd2, 4'd0, 64'h10);
    tick();
    chk("bad.len0.err",   64'(err_req), 64'd1);
    chk("bad.len0.ready", 64'(req_ready), 64'd1);
    chk("bad.len0.valid", 64'(flit_valid), 64'd0);
    set_req(3'd2, 4'd9, 64'h20);
    tick();
    chk("bad.len9.err",   64'(err_req), 64'd1);
    chk("bad.len9.busy",  64'(busy), 64'd0);
    set_req(3'd6, 4'd2, 64'h30);
    tick();
    chk("bad.dest6.err",   64'(err_req), 64'd1);
    chk("bad.dest6.valid", 64'(flit_valid), 64'd0);
    req_valid = 1'b0;
    tick();
    chk("bad.err.clear", 64'(err_req), 64'd0);
    chk("bad.valid",     64'(flit_valid), 64'd0);
    chk("bad.cnt",       64'(credit_cnt), 64'd4);

    // Reset in the middle of an 8-flit packet.
    set_req(3'd5, 4'd8, 64'hD0);
    tick();
    req_valid = 1'b0;
    tick();
    exp_flit("p4.f0", 64'hD0, 1'b0, 3'd5, 3'd3);
    tick();
    exp_flit("p4.f1", 64'hD1, 1'b0, 3'd5, 3'd2);
    rst_n = 1'b0;
    #1;
    chk("p4.rst.valid", 64'(flit_valid), 64'd0);
    chk("p4.rst.last",  64'(flit_last), 64'd0);
    chk("p4.rst.cnt",   64'(credit_cnt), 64'd4);
    chk("p4.rst.ready", 64'(req_ready), 64'd1);
    chk("p4.rst.busy",  64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("p4.post.valid", 64'(flit_valid), 64'd0);
    set_req(3'd2, 4'd1, 64'hE0);
    tick();
    req_valid = 1'b0;
    tick();
    exp_flit("p5.f0", 64'hE0, 1'b1, 3'd2, 3'd3);
    chk("p5.ready", 64'(req_ready), 64'd1);
    tick();
    chk("p5.after.valid", 64'(flit_valid), 64'd0);

    // Back-to-back packets with one bubble; post-accept req_data changes ignored.
    pulse_credit();
    chk("p6.pre.cnt", 64'(credit_cnt), 64'd4);
    set_req(3'd4, 4'd2, 64'hF0);
    tick();
    set_req(3'd0, 4'd3, 64'h50);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    exp_flit("p6.f0", 64'hF0, 1'b0, 3'd4, 3'd4);
    chk("p6.f0.ready", 64'(req_ready), 64'd0);
    tick();
    exp_flit("p6.f1", 64'hF1, 1'b1, 3'd4, 3'd3);
    chk("p6.f1.ready", 64'(req_ready), 64'd1);
    tick();
    chk("p6.bubble.valid", 64'(flit_valid), 64'd0);
    chk("p6.bubble.busy",  64'(busy), 64'd1);
    set_req(3'd1, 4'd5, 64'hEE00);
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_flit($sformatf("p7.f%0d", k), 64'h50 + 64'(k), (k == 2), 3'd0, 3'(2 - k));
    end
    chk("p7.ready", 64'(req_ready), 64'd1);
    tick();
    chk("p7.after.valid", 64'(flit_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
- Node-side network-interface transmitter that feeds one input port of the mesh router.
- Accepts a whole message (destination plus up to MAX_FLITS payload words) over a valid/ready request interface, buffers it, then emits it as a sequence of flits (data, valid, last, dest) to the router.
- Injection is governed by credit-based flow control: one credit is consumed per flit, and the router returns credits on credit_in.

Parameters:
- NODES, 6, number of mesh nodes; dest field width DW = $clog2(NODES).
- FLIT_WIDTH, 64, flit payload width in bits.
- MAX_FLITS, 8, maximum flits per packet; length field width LW = $clog2(MAX_FLITS+1).
- CREDITS, 4, router input buffer depth; counter width CW = $clog2(CREDITS+1).

Ports:
- clk  in  1  sole clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  message request valid.
- req_ready  out  1  block can accept a message (combinational: state==IDLE).
- req_dest  in  DW  destination node id.
- req_len  in  LW  flit count, legal 1..MAX_FLITS.
- req_data  in  MAX_FLITS*FLIT_WIDTH  payload; word i = bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- flit_valid  out  1  registered flit valid (one flit per cycle max).
- flit_data  out  FLIT_WIDTH  registered flit payload.
- flit_last  out  1  registered; high on the final flit of the packet.
- flit_dest  out  DW  registered; the packet destination, constant across the packet.
- credit_in  in  1  one-cycle pulse returning one credit.
- credit_cnt  out  CW  current credits (debug).
- busy  out  1  state==SEND.
- err_req  out  1  one-cycle pulse when an illegal request is dropped.
- err_credit  out  1  one-cycle pulse when a credit overflows.

Behaviour:
- Reset (async assert) sets: state=IDLE, flit_valid=0, flit_data=0, flit_last=0, flit_dest=0, credit_cnt=CREDITS, beat index=0, err_req=0, err_credit=0, busy=0.
- Reset mid-packet abandons the packet. No flit_last is sent.
- FSM IDLE:
  - req_ready=1.
  - On an edge with req_valid&&req_ready, validate the request.
  - Illegal request (req_len==0, req_len>MAX_FLITS, or req_dest>=NODES): consume it, pulse err_req on the next cycle, stay in IDLE, emit no flits.
  - Legal request: latch req_data, req_dest and req_len; set idx=0; go to SEND.
- FSM SEND:
  - req_ready=0.
  - On each edge with credit_cnt>0: load flit_valid=1, flit_data=word[idx], flit_dest=latched dest, flit_last=(idx==len-1); increment idx; decrement credit.
  - If that flit was the last, go to IDLE on the same edge.
  - On an edge with credit_cnt==0: flit_valid<=0 and idx holds (stall).
  - In IDLE, flit_valid<=0 every edge.
- Latency:
  - Request accepted on edge N; flit k (0-based) is visible after edge N+1+k when no stalls occur.
  - Back-to-back packets have one bubble cycle (earliest next accept is edge N+len+1).
- Credits:
  - Credit decision uses the registered credit_cnt only. A credit_in arriving in the same cycle is usable from the next edge.
  - Per edge, next count = cnt − send + credit_in. A simultaneous send and credit_in leaves the count unchanged.
  - credit_in with cnt==CREDITS and no send: saturate at CREDITS and pulse err_credit.
  - The counter never underflows, because a send requires cnt>0.
- Data width: the payload is never modified; flit_data is exactly the selected req_data word.
- Latched message fields are unaffected by req_* changes after acceptance.

Decomposition:
- noc_pkg:
  - flit_t packed struct {data, valid, last, dest}, with widths from package localparams FLIT_WIDTH_DEF and NODES_DEF.
  - Enum pkt_state_e {IDLE, SEND}.
  - Function dest_w(NODES).
- Sub-module noc_credit_counter (params CREDITS; ports clk, rst_n, consume, credit_in, cnt, avail, overflow_err).
  - Owns the saturation and simultaneous-event rules.
  - Reused later by the router input ports.

Test Plan:
- Reset, then dest=3, len=4, words 0xA0..0xA3, credit_in never pulsed -> flits A0..A3 on 4 consecutive cycles starting one cycle after acceptance; flit_last only on A3; flit_dest=3; credit_cnt ends at 0; req_ready high after the last flit.
- len=6, no credits returned -> 4 flits sent, flit_valid=0 while credit_cnt==0; one credit_in pulse -> exactly one more flit one edge later; second pulse -> final flit with last=1.
- Steady state, credit_cnt=2: pulse credit_in on the same cycle as a send -> credit_cnt stays 2; credit_in at credit_cnt=4 while idle -> stays 4 and err_credit pulses for 1 cycle.
- Requests with len=0, len=9, and dest=6 -> each consumed in 1 cycle, err_req pulse each, flit_valid never asserted, credit_cnt unchanged.
- Assert rst_n low after flit 2 of an 8-flit packet -> flit_valid drops immediately, credit_cnt=4, state IDLE; a new len=1 packet afterwards sends a single flit with last=1.
- Two legal packets offered back-to-back (len=2, then len=3) with ample credits -> exactly one flit_valid=0 bubble between them; req_data changes after acceptance do not affect emitted data.
